// File: rtl/serial_pat_match.sv
// serial_pat_match: serial bit-pattern detector with a runtime-programmable pattern.
// It shifts in one bit per cycle when data_valid_i is high. Once PAT_W bits have
// arrived, it compares the latest PAT_W bits against the pattern register. A match
// raises a one-cycle registered flag_o and bumps a saturating counter. Overlapping
// detection is selected at runtime.
//
// Optional feature: define SERIAL_PAT_MASK_EN to add cfg_mask_i. Only pattern bits
// whose mask bit is 1 are compared. The mask resets to all ones.
//
// Ports:
//   clk_i          clock; all state updates on the rising edge
//   reset_i        synchronous active-high reset; overrides every other input
//   data_i         serial data bit
//   data_valid_i   data_i is accepted only while this is high
//   cfg_load_i     strobe: latch cfg_pattern_i/cfg_overlap_i, flush history and count
//   cfg_pattern_i  new pattern; bit PAT_W-1 is the oldest bit on the wire
//   cfg_overlap_i  1 = overlapping matches, 0 = restart after each match
//   cfg_mask_i     (SERIAL_PAT_MASK_EN only) per-bit compare enable
//   flag_o         registered match pulse
//   match_cnt_o    saturating count of flag_o pulses
//   armed_o        history holds PAT_W valid bits
module serial_pat_match #(
  parameter int unsigned      PAT_W   = 7,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 7'b1010111,
  parameter logic             RST_OVL = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             data_i,
  input  logic             data_valid_i,
  input  logic             cfg_load_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic             cfg_overlap_i,
`ifdef SERIAL_PAT_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask_i,
`endif
  output logic             flag_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             armed_o
);

  localparam int unsigned      FillW   = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_W);

  typedef enum logic [0:0] {StFill, StArmed} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic               ovl_q, ovl_d;
  // The oldest bit leaves the window on every shift, so only PAT_W-1 bits are kept.
  // The incoming bit completes the PAT_W-bit compare window.
  logic [PAT_W-2:0]   hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_W-1:0]   cmp_mask;
  logic [PAT_W-1:0]   window;
  logic [FillW-1:0]   fill_inc;
  logic               hit;

`ifdef SERIAL_PAT_MASK_EN
  logic [PAT_W-1:0]   mask_q, mask_d;
  assign cmp_mask = mask_q;
`else
  assign cmp_mask = '1;
`endif

  assign window   = {hist_q, data_i};
  assign fill_inc = (state_q == StArmed) ? FillMax : fill_q + 1'b1;
  assign hit      = (fill_inc == FillMax) && (((window ^ pat_q) & cmp_mask) == '0);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    flag_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef SERIAL_PAT_MASK_EN
    mask_d  = mask_q;
`endif
    if (cfg_load_i) begin
      // A load flushes history, so any bit arriving in the same cycle is dropped.
      pat_d   = cfg_pattern_i;
      ovl_d   = cfg_overlap_i;
`ifdef SERIAL_PAT_MASK_EN
      mask_d  = cfg_mask_i;
`endif
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
      state_d = StFill;
    end else if (data_valid_i) begin
      hist_d  = window[PAT_W-2:0];
      fill_d  = fill_inc;
      state_d = (fill_inc == FillMax) ? StArmed : StFill;
      if (hit) begin
        flag_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (!ovl_q) begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = StFill;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StFill;
      pat_q   <= RST_PAT;
      ovl_q   <= RST_OVL;
      hist_q  <= '0;
      fill_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_PAT_MASK_EN
      mask_q  <= '1;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_PAT_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign flag_o      = flag_q;
  assign match_cnt_o = cnt_q;
  assign armed_o     = (state_q == StArmed);

endmodule

// File: tb/tb_serial_pat_match.sv
// Randomised and directed bench for serial_pat_match in its default build.
// Two instances share the same stimulus: one uses the default counter width and
// one uses a 2-bit counter to reach saturation.
module tb_serial_pat_match;

  localparam int unsigned PW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          data = 1'b0;
  logic          valid = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] cfg_pat = '0;
  logic          cfg_ovl = 1'b0;

  logic          flag_a, armed_a, flag_b, armed_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  serial_pat_match dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .data_i        (data),
    .data_valid_i  (valid),
    .cfg_load_i    (load),
    .cfg_pattern_i (cfg_pat),
    .cfg_overlap_i (cfg_ovl),
    .flag_o        (flag_a),
    .match_cnt_o   (cnt_a),
    .armed_o       (armed_a)
  );

  serial_pat_match #(.CNT_W(2)) dut_c2 (
    .clk_i         (clk),
    .reset_i       (reset),
    .data_i        (data),
    .data_valid_i  (valid),
    .cfg_load_i    (load),
    .cfg_pattern_i (cfg_pat),
    .cfg_overlap_i (cfg_ovl),
    .flag_o        (flag_b),
    .match_cnt_o   (cnt_b),
    .armed_o       (armed_b)
  );

  typedef struct packed {
    logic       flag;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       armed;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: a list of accepted bits since the last flush.
  bit            m_bits[$];
  logic [PW-1:0] m_pat = 7'b1010111;
  logic          m_ovl = 1'b1;
  int            m_cnt = 0;
  int            m_cnt2 = 0;
  logic          m_flag = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  task automatic model(input logic r, input logic l, input logic [PW-1:0] p,
                       input logic o, input logic v, input logic d);
    int win;
    m_flag = 1'b0;
    if (r) begin
      m_bits.delete();
      m_pat = 7'b1010111;
      m_ovl = 1'b1;
      m_cnt = 0;
      m_cnt2 = 0;
    end else if (l) begin
      m_bits.delete();
      m_pat = p;
      m_ovl = o;
      m_cnt = 0;
      m_cnt2 = 0;
    end else if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() > PW) void'(m_bits.pop_front());
      if (m_bits.size() == PW) begin
        win = 0;
        foreach (m_bits[i]) win = win * 2 + int'(m_bits[i]);
        if (win == int'(m_pat)) begin
          m_flag = 1'b1;
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
          if (!m_ovl) m_bits.delete();
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [PW-1:0] p,
                      input logic o, input logic v, input logic d);
    exp_t e;
    @(negedge clk);
    reset = r; load = l; cfg_pat = p; cfg_ovl = o; valid = v; data = d;
    model(r, l, p, o, v, d);
    e.flag  = m_flag;
    e.cnt   = 8'(m_cnt);
    e.cnt2  = 2'(m_cnt2);
    e.armed = (m_bits.size() == PW);
    exp_q.push_back(e);
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, s[i] == "1");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [PW-1:0] p, input logic o);
    step(1'b0, 1'b1, p, o, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are registered, so one expected entry is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("flag",        int'(flag_a),  int'(e.flag));
        chk("match_cnt",   int'(cnt_a),   int'(e.cnt));
        chk("armed",       int'(armed_a), int'(e.armed));
        chk("flag_c2",     int'(flag_b),  int'(e.flag));
        chk("match_cnt_c2", int'(cnt_b),  int'(e.cnt2));
        chk("armed_c2",    int'(armed_b), int'(e.armed));
      end
    end
  end

  initial begin
    int idx;
    logic r, l, o, v, d;
    logic [PW-1:0] p;

    // Reset values, then the default pattern.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    feed("1010111");
    idle(2);

    // Overlap on.
    cfg(7'b1010101, 1'b1);
    feed("101010101");
    idle(1);

    // Overlap off.
    cfg(7'b1010101, 1'b0);
    feed("101010101");
    feed("1010101");
    idle(1);

    // Valid gaps, then a load coinciding with a valid bit.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    feed("1010");
    idle(3);
    feed("111");
    step(1'b0, 1'b1, 7'b1010111, 1'b1, 1'b1, 1'b1);
    idle(1);

    // Saturation of the narrow counter, then reset mid-stream.
    cfg(7'b1111111, 1'b1);
    feed("1111111111");
    cfg(7'b1111111, 1'b1);
    feed("11111");
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cfg(7'b1111111, 1'b1);
    feed("1111111");
    idle(1);

    // Randomised traffic, biased towards the current pattern.
    idx = 0;
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 59) == 0);
      p = PW'($urandom);
      o = 1'($urandom);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) d = m_pat[PW-1-idx];
      else d = 1'($urandom);
      if (r || l) idx = 0;
      else if (v) idx = (idx == PW - 1) ? 0 : idx + 1;
      step(r, l, p, o, v, d);
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
